instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: owns the PC and drives the byte address each cycle.
- Takes the same-cycle combinational instruction word and registers {pc, pc+4, instr} into an IF/ID output stage with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute.
- Enters a sticky FAULT state on misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; legal byte range is 0 .. 4*IMEM_WORDS-1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals the PC register.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  execute requests a PC change this cycle.
- redirect_target  input  32  new byte PC when redirect_valid=1.
- out_valid  output  1  IF/ID register holds a valid instruction.
- out_ready  input  1  decode accepts out_* this cycle.
- out_instr  output  32  registered instruction.
- out_pc  output  32  byte address of out_instr.
- out_pc_plus4  output  32  out_pc + 4.
- fault  output  1  fetch stopped on an illegal address.
- fault_pc  output  32  offending address, latched on FAULT entry.
- fetch_count  output  32  number of completed out handshakes; wraps modulo 2^32.

Behaviour:
- Reset (synchronous, active-high, overrides everything, legal mid-operation):
  - pc=RESET_PC; state=RUN; out_valid=0; out_instr=0; out_pc=0; out_pc_plus4=0; fault=0; fault_pc=0; fetch_count=0.
- States:
  - RUN: fetching.
  - FAULT: no capture, pc frozen, fault=1.
- Address legality: addr is legal iff addr[1:0]==0 and addr < 4*IMEM_WORDS.
- imem_addr = pc at all times, including in FAULT.
- Transfer: a transfer happens when out_valid && out_ready. fetch_count increments on every transfer, including on a redirect cycle.
- Capture condition, evaluated per cycle in RUN with no redirect: capture when (!out_valid || out_ready).
  - On capture: out_instr<=imem_instr; out_pc<=pc; out_pc_plus4<=pc+4; out_valid<=1; pc<=pc+4.
  - Otherwise: pc and the out_* registers hold.
- Latency: an instruction appears on out_* one cycle after its address is driven. Throughput is 1 instruction/cycle while out_ready=1.
- Sequential overflow: if a capture makes pc+4 illegal (e.g. pc=4*IMEM_WORDS-4), the capture still completes. Next state is FAULT with fault_pc=pc+4 and pc<=pc+4.
- Redirect (highest priority after reset, valid in both RUN and FAULT):
  - out_valid<=0 (younger fetch squashed); no capture that cycle.
  - Legal target: pc<=redirect_target, state<=RUN, fault<=0.
  - Illegal target: pc<=redirect_target, state<=FAULT, fault<=1, fault_pc<=redirect_target.
  - A handshake on the redirect cycle still counts as a transfer. Decode squashes that instruction with its own flush.
- FAULT without redirect:
  - Capture is disabled.
  - out_valid clears only after a pending out word transfers.
  - Exit is only via reset or a legal redirect.
- out_* hold stable while out_valid && !out_ready.
- pc arithmetic is 32-bit unsigned; no wrap is reachable, because the range check triggers first.

Decomposition:
- Shared package fetch_pkg:
  - state enum {RUN, FAULT}
  - NOP_INSTR = 32'h0000_0000
  - default RESET_PC
  - addr_legal helper function parameterised by IMEM_WORDS
- Sub-module ifid_stage_reg: the out_* register with valid/ready hold logic and fetch_count. The top level keeps the PC, FSM and redirect logic.

Test Plan:
1. Reset, then out_ready=1 held for 4 cycles with the default memory image -> out_pc 0,4,8,C with out_instr 8C010000, 8C020004, 8C030008, 20040064 on consecutive cycles; fetch_count=4.
2. out_ready=0 for 3 cycles while out_valid=1 holding pc=4 -> out_* stable at 8C020004, imem_addr stays 8, fetch_count unchanged; raising out_ready resumes with pc=8 next.
3. redirect_valid=1, target=0x1C while out_valid=1 -> next cycle out_valid=0, imem_addr=0x1C; following cycle out_instr=10600002, out_pc_plus4=0x20.
4. redirect to 0x0000_0006, then to 0x0000_1000 -> each gives fault=1 with fault_pc=6 / 0x1000 and no further out_valid. A subsequent redirect to 0x24 -> fault=0, out_instr=AC060000.
5. Redirect to 0xFFC with out_ready=1 -> one transfer with out_pc=0xFFC, then fault=1 and fault_pc=0x1000.
6. Assert reset mid-stream with out_valid=1 and fault=1 -> next cycle all outputs at reset values and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types, constants and helpers for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int unsigned DEFAULT_IMEM_WORDS = 1024;

  // A fetch address is usable only if word aligned and inside the memory.
  // The compare is done at 34 bits so the byte limit itself cannot overflow.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned imem_words);
    logic [33:0] byte_limit;
    byte_limit = 34'(imem_words) << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < byte_limit);
  endfunction

endpackage

// File: rtl/ifid_stage_reg.sv
// IF/ID pipeline register: holds one fetched instruction with its PC and
// PC+4, implements valid/ready holding toward decode, and counts transfers.
module ifid_stage_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        flush,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] fetch_count
);

  logic transfer;

  assign transfer = out_valid && out_ready;

  // Register update: flush squashes, capture loads, otherwise hold until taken.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      out_valid    <= 1'b0;
      out_instr    <= NOP_INSTR;
      out_pc       <= 32'h0000_0000;
      out_pc_plus4 <= 32'h0000_0000;
      fetch_count  <= 32'h0000_0000;
    end else begin
      // A handshake completes even on a flush cycle; decode discards it.
      if (transfer) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid    <= 1'b1;
        out_instr    <= in_instr;
        out_pc       <= in_pc;
        out_pc_plus4 <= in_pc + 32'd4;
      end else if (out_ready) begin
        // Only reachable with fetching stopped: drain the pending word.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory address,
// handles execute redirects and stops in a sticky fault on illegal addresses.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next, pc_plus4;
  logic [31:0]  fault_pc_next;
  logic         capture;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign fault     = (state == FAULT);

  // Next-state logic: redirect beats sequential fetch; overflow faults after capture.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    state_next    = state;
    pc_next       = pc;
    fault_pc_next = fault_pc;
    capture       = 1'b0;

    if (redirect_valid) begin
      pc_next = redirect_target;
      if (addr_legal(redirect_target, IMEM_WORDS)) begin
        state_next = RUN;
      end else begin
        state_next    = FAULT;
        fault_pc_next = redirect_target;
      end
    end else if (state == RUN && (!out_valid || out_ready)) begin
      capture = 1'b1;
      pc_next = pc_plus4;
      if (!addr_legal(pc_plus4, IMEM_WORDS)) begin
        state_next    = FAULT;
        fault_pc_next = pc_plus4;
      end
    end
  end

  // State register for PC, FSM state and the latched fault address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      fault_pc <= 32'h0000_0000;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      fault_pc <= fault_pc_next;
    end
  end

  ifid_stage_reg u_ifid (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .flush        (redirect_valid),
    .in_instr     (imem_instr),
    .in_pc        (pc),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .fetch_count  (fetch_count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a behavioural instruction
// memory, a transfer scoreboard and directed redirect/fault sequences.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] imem [0:1023];
  xfer_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] seen_xfers = 32'h0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 32'hE000_0000 | 32'(i);
    imem[0] = 32'h8C01_0000;
    imem[1] = 32'h8C02_0004;
    imem[2] = 32'h8C03_0008;
    imem[3] = 32'h2004_0064;
    imem[7] = 32'h1060_0002;
    imem[9] = 32'hAC06_0000;
  end

  assign imem_instr = (imem_addr < 32'h0000_1000) ? imem[imem_addr[11:2]] : 32'h0;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pc_plus4    (out_pc_plus4),
    .fault           (fault),
    .fault_pc        (fault_pc),
    .fetch_count     (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    xfer_t x;
    x.pc    = pc;
    x.instr = imem[pc[11:2]];
    exp_q.push_back(x);
  endtask

  // Scoreboard: every completed handshake must match the next expected word,
  // and the DUT counter must equal the handshakes seen so far.
  always @(negedge clk) begin
    if (reset) begin
      seen_xfers = 32'h0;
    end else begin
      check("fetch_count", fetch_count, seen_xfers);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("xfer_queue_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          check("xfer_pc", out_pc, e.pc);
          check("xfer_instr", out_instr, e.instr);
          check("xfer_pc_plus4", out_pc_plus4, e.pc + 32'd4);
        end
        seen_xfers = seen_xfers + 32'd1;
      end
    end
  end

  task automatic check_reset_values();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_pc_plus4", out_pc_plus4, 32'h0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_pc", fault_pc, 32'h0);
    check("rst_fetch_count", fetch_count, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
  endtask

  initial begin
    // Reset
    step();
    step();
    check_reset_values();

    // Straight-line fetch at full throughput
    for (int i = 0; i < 4; i++) push(32'(4 * i));
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("seq_out_pc", out_pc, 32'(4 * i));
      check("seq_out_valid", 32'(out_valid), 32'd1);
    end
    step();
    out_ready = 1'b0;
    check("seq_fetch_count", fetch_count, 32'd4);

    // Backpressure holds the IF/ID word and the PC
    redirect_valid  = 1'b1;
    redirect_target = 32'h4;
    step();
    check("bp_redirect_squash", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    step();
    check("bp_out_pc", out_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_instr", out_instr, 32'h8C02_0004);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_imem_addr", imem_addr, 32'h8);
      check("bp_hold_count", fetch_count, 32'd4);
    end
    push(32'h4);
    out_ready = 1'b1;
    step();
    check("bp_resume_pc", out_pc, 32'h8);
    check("bp_resume_instr", out_instr, 32'h8C03_0008);

    // Redirect with a transfer on the same cycle
    push(32'h8);
    redirect_valid  = 1'b1;
    redirect_target = 32'h1C;
    step();
    check("rd_out_valid", 32'(out_valid), 32'd0);
    check("rd_imem_addr", imem_addr, 32'h1C);
    check("rd_count", fetch_count, 32'd6);
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    step();
    check("rd_out_instr", out_instr, 32'h1060_0002);
    check("rd_out_pc_plus4", out_pc_plus4, 32'h20);

    // Misaligned and out-of-range redirects, then recovery
    redirect_valid  = 1'b1;
    redirect_target = 32'h6;
    step();
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_fault_pc", fault_pc, 32'h6);
    check("mis_imem_addr", imem_addr, 32'h6);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("mis_no_valid", 32'(out_valid), 32'd0);
      check("mis_pc_frozen", imem_addr, 32'h6);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h1000;
    step();
    check("oor_fault", 32'(fault), 32'd1);
    check("oor_fault_pc", fault_pc, 32'h1000);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("oor_no_valid", 32'(out_valid), 32'd0);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h24;
    step();
    check("rec_fault", 32'(fault), 32'd0);
    check("rec_imem_addr", imem_addr, 32'h24);
    redirect_valid = 1'b0;
    step();
    check("rec_out_instr", out_instr, 32'hAC06_0000);
    check("rec_out_valid", 32'(out_valid), 32'd1);

    // Sequential overflow off the end of memory
    push(32'h24);
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFC;
    out_ready       = 1'b1;
    step();
    check("ovf_squash", 32'(out_valid), 32'd0);
    redirect_valid = 1'b0;
    push(32'hFFC);
    step();
    check("ovf_out_pc", out_pc, 32'hFFC);
    check("ovf_fault", 32'(fault), 32'd1);
    check("ovf_fault_pc", fault_pc, 32'h1000);
    check("ovf_imem_addr", imem_addr, 32'h1000);
    step();
    check("ovf_drained", 32'(out_valid), 32'd0);
    step();
    check("ovf_stays_empty", 32'(out_valid), 32'd0);

    // Pending word held in FAULT, then reset mid-stream
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFC;
    out_ready       = 1'b0;
    step();
    redirect_valid = 1'b0;
    step();
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_fault", 32'(fault), 32'd1);
    step();
    check("mid_hold_valid", 32'(out_valid), 32'd1);
    check("mid_hold_pc", out_pc, 32'hFFC);
    reset = 1'b1;
    step();
    check_reset_values();
    reset = 1'b0;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_instr", out_instr, 32'h8C01_0000);
    check("post_rst_imem_addr", imem_addr, 32'h4);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
